acc_buffer: RTL and testbench
=============================

# acc_buffer

Parametrised multi-lane result buffer at the output of the systolic array. Captures one row of LANES column partial sums per accepted beat into a DEPTH-row store, either overwriting or adding into the stored row, so K-split tiles can be summed over several passes. Drains the finished rows through a valid/ready stream to the writeback path. Full/empty flags are registered and exact: `full` asserts on the cycle after the DEPTH-th write, never earlier or later.

## Interface
- DATA_W, 32, width of one lane's value (signed two's complement)
- DEPTH, 4, number of rows stored (≥2)
- LANES, 2, values per row (array columns)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input row present
- in_data  in  LANES*DATA_W  input row; lane i at bits [i*DATA_W +: DATA_W]
- in_accum  in  1  1 = add into stored row, 0 = overwrite
- in_ready  out  1  buffer accepts a row this cycle
- rewind  in  1  pulse: restart write pointer for another accumulate pass
- drain  in  1  pulse: start streaming stored rows out
- out_valid  out  1  out_data holds a row
- out_data  out  LANES*DATA_W  row at read pointer
- out_last  out  1  current out row is row DEPTH-1
- out_ready  in  1  consumer accepts out row
- full  out  1  DEPTH rows written in current pass
- empty  out  1  no row written in current pass
- count  out  $clog2(DEPTH+1)  rows written in current pass

## Operation
- States: FILL, FULL, DRAIN. Reset state FILL.
- in_ready = (state == FILL). Write accepted when in_valid && in_ready; zero-valued rows are written like any other.
- Accepted write to row wr_ptr: in_accum=0 stores in_data; in_accum=1 stores per-lane row[wr_ptr][i] + in_data[i] (width rule below). wr_ptr and count increment.
- FILL → FULL on the accepted write that makes count == DEPTH; wr_ptr wraps to 0.
- FULL, rewind: → FILL, wr_ptr=0, count=0, contents retained.
- FULL, drain: → DRAIN, rd_ptr=0. drain and rewind in the same cycle: drain wins, rewind dropped.
- drain or rewind in FILL or DRAIN: ignored.
- DRAIN: out_valid=1, out_data = row[rd_ptr], out_last = (rd_ptr == DEPTH-1). On out_valid && out_ready rd_ptr increments; on the handshake with out_last → FILL, count=0, wr_ptr=0, rd_ptr=0. Contents are not cleared; the first pass after a drain uses in_accum=0.
- Lanes are independent; no cross-lane arithmetic.
- Arithmetic: DATA_W-bit signed add, result DATA_W bits; overflow handling per Configuration.

## Timing
- Reset (async, immediate on reset_n low): state FILL, in_ready=1, empty=1, full=0, count=0, out_valid=0, out_last=0, out_data=0, all pointers 0, all rows 0.
- Write latency: row visible in store on the edge accepting it; accum read-modify-write completes in that same cycle, so back-to-back accum beats to consecutive rows run at one row/cycle.
- full, empty, count, in_ready registered, all update on the edge following the causing event; in_ready=0 in the first cycle full=1.
- drain pulse in cycle N: out_valid=1 and row 0 on out_data from cycle N+1.
- out_data, out_last stable while out_valid && !out_ready.
- After last out handshake in cycle M: out_valid=0, in_ready=1, empty=1 in cycle M+1.
- reset_n low mid-pass or mid-drain: all state to reset values; partial drain is abandoned.

## Configuration
- ACC_SATURATE_EN defined: accumulate add saturates per lane to 2^(DATA_W-1)-1 on positive overflow and -2^(DATA_W-1) on negative overflow.
- Not defined: add wraps modulo 2^DATA_W. Overwrite path unaffected either way; ports identical.

## Test plan
- Reset with DATA_W=32, DEPTH=4, LANES=2 -> in_ready=1, empty=1, full=0, count=0, out_valid=0, out_data=0.
- Overwrite rows (1,2),(3,4),(5,6),(7,8) back-to-back -> full=1 and in_ready=0 the cycle after 4th beat; 5th in_valid beat (9,9) not stored.
- rewind, then accum rows (10,10) x4, then drain with out_ready=1 -> out rows (11,12),(13,14),(15,16),(17,18) on consecutive cycles, out_last only on 4th, in_ready=1 the cycle after.
- During drain hold out_ready=0 for 3 cycles on row 1 -> out_data stays (13,14), rd_ptr does not advance; drain/rewind pulses during DRAIN ignored.
- Row holds (0x7FFFFFFF, 0x80000000), accum (1, -1) -> with ACC_SATURATE_EN (0x7FFFFFFF, 0x80000000); without (0x80000000, 0x7FFFFFFF).
- reset_n low after 2 drained rows -> out_valid=0 immediately; after release empty=1, count=0, stored rows read back 0 after refill-free FULL is impossible (full=0).

Source files
------------

// File: rtl/acc_buffer.sv
// acc_buffer: DEPTH-row multi-lane result store with overwrite/accumulate writes and valid/ready drain.
// Optional ACC_SATURATE_EN: accumulate saturates per lane instead of wrapping.
`default_nettype none

module acc_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LANES  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic                       in_accum,
  output logic                       in_ready,
  input  logic                       rewind,
  input  logic                       drain,
  output logic                       out_valid,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [PTR_W-1:0]        wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0]        rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]        count_n;
  logic [LANES*DATA_W-1:0] mem [DEPTH];
  logic [LANES*DATA_W-1:0] cur_row;
  logic [LANES*DATA_W-1:0] acc_row;
  logic                    wr_en;
  logic                    rd_hs;

  assign wr_en    = in_valid && in_ready;
  assign rd_hs    = out_valid && out_ready;
  assign cur_row  = mem[wr_ptr];
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign out_last = out_valid && (rd_ptr == LAST_PTR);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] a, b, s;
    assign a = cur_row[i*DATA_W +: DATA_W];
    assign b = in_data[i*DATA_W +: DATA_W];
    assign s = a + b;
`ifdef ACC_SATURATE_EN
    // Overflow only when both operands share a sign the result does not.
    logic ovf;
    assign ovf = (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    assign acc_row[i*DATA_W +: DATA_W] = !ovf ? s :
        (a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
`else
    assign acc_row[i*DATA_W +: DATA_W] = s;
`endif
  end

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    case (state)
      S_FILL: begin
        if (wr_en) begin
          count_n  = count + 1'b1;
          wr_ptr_n = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
          if (count + 1'b1 == FULL_CNT) state_n = S_FULL;
        end
      end
      S_FULL: begin
        if (drain) begin
          state_n  = S_DRAIN;
          rd_ptr_n = '0;
        end else if (rewind) begin
          state_n  = S_FILL;
          wr_ptr_n = '0;
          count_n  = '0;
        end
      end
      S_DRAIN: begin
        if (rd_hs) begin
          if (rd_ptr == LAST_PTR) begin
            state_n  = S_FILL;
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            count_n  = '0;
          end else begin
            rd_ptr_n = rd_ptr + 1'b1;
          end
        end
      end
      default: state_n = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      full      <= (count_n == FULL_CNT);
      empty     <= (count_n == '0);
      in_ready  <= (state_n == S_FILL);
      out_valid <= (state_n == S_DRAIN);
      if (wr_en) mem[wr_ptr] <= in_accum ? acc_row : in_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acc_buffer.sv
// tb_acc_buffer: directed self-checking bench for acc_buffer (DATA_W=32, DEPTH=4, LANES=2).
`default_nettype none

module tb_acc_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LANES  = 2;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    in_valid, in_accum, in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    rewind, drain;
  logic                    out_valid, out_last, out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    full, empty;
  logic [2:0]              count;

  int n_checks = 0;
  int n_fail   = 0;

  acc_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_accum(in_accum), .in_ready(in_ready),
    .rewind(rewind), .drain(drain),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] row(input logic [31:0] l0, input logic [31:0] l1);
    return {l1, l0};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, ".in_ready"},  64'(in_ready),  64'd1);
    check_val({tag, ".empty"},     64'(empty),     64'd1);
    check_val({tag, ".full"},      64'(full),      64'd0);
    check_val({tag, ".count"},     64'(count),     64'd0);
    check_val({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, ".out_last"},  64'(out_last),  64'd0);
    check_val({tag, ".out_data"},  out_data,       64'd0);
  endtask

  task automatic put(input logic [63:0] d, input logic acc);
    in_valid = 1'b1; in_data = d; in_accum = acc;
    tick();
    in_valid = 1'b0; in_accum = 1'b0;
  endtask

  logic [63:0] sat_exp;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_accum = 1'b0;
    rewind = 1'b0; drain = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_idle("reset");
    reset_n = 1'b1;
    tick();

    // Overwrite pass
    for (int i = 0; i < DEPTH; i++) begin
      put(row(32'(2*i+1), 32'(2*i+2)), 1'b0);
      if (i == 0) begin
        check_val("ovw.count1", 64'(count), 64'd1);
        check_val("ovw.empty1", 64'(empty), 64'd0);
      end
    end
    check_val("ovw.full",     64'(full),     64'd1);
    check_val("ovw.in_ready", 64'(in_ready), 64'd0);
    check_val("ovw.count4",   64'(count),    64'd4);
    put(row(32'd9, 32'd9), 1'b0);
    check_val("ovw.5th.count", 64'(count), 64'd4);
    check_val("ovw.5th.full",  64'(full),  64'd1);

    // Rewind then accumulate pass
    rewind = 1'b1; tick(); rewind = 1'b0;
    check_val("rew.full",     64'(full),     64'd0);
    check_val("rew.empty",    64'(empty),    64'd1);
    check_val("rew.count",    64'(count),    64'd0);
    check_val("rew.in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < DEPTH; i++) put(row(32'd10, 32'd10), 1'b1);
    check_val("acc.full", 64'(full), 64'd1);

    // Drain with a 3-cycle stall on row 1 and ignored pulses
    drain = 1'b1; rewind = 1'b1; tick(); drain = 1'b0; rewind = 1'b0;
    check_val("drn.valid0", 64'(out_valid), 64'd1);
    check_val("drn.row0",   out_data, row(32'd11, 32'd12));
    check_val("drn.last0",  64'(out_last), 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drain = 1'b1; rewind = 1'b1; tick();
      check_val("stall.row1",  out_data, row(32'd13, 32'd14));
      check_val("stall.valid", 64'(out_valid), 64'd1);
      check_val("stall.last",  64'(out_last), 64'd0);
    end
    drain = 1'b0; rewind = 1'b0; out_ready = 1'b1;
    tick();
    check_val("drn.row2",  out_data, row(32'd15, 32'd16));
    check_val("drn.last2", 64'(out_last), 64'd0);
    tick();
    check_val("drn.row3",  out_data, row(32'd17, 32'd18));
    check_val("drn.last3", 64'(out_last), 64'd1);
    tick();
    out_ready = 1'b0;
    check_val("post.valid",    64'(out_valid), 64'd0);
    check_val("post.in_ready", 64'(in_ready),  64'd1);
    check_val("post.empty",    64'(empty),     64'd1);
    drain = 1'b1; tick(); drain = 1'b0;
    check_val("fill.drain.valid", 64'(out_valid), 64'd0);
    check_val("fill.drain.ready", 64'(in_ready),  64'd1);

    // Overflow on accumulate
    put(row(32'h7FFF_FFFF, 32'h8000_0000), 1'b0);
    for (int i = 1; i < DEPTH; i++) put(64'd0, 1'b0);
    rewind = 1'b1; tick(); rewind = 1'b0;
    put(row(32'd1, 32'hFFFF_FFFF), 1'b1);
    for (int i = 1; i < DEPTH; i++) put(64'd0, 1'b1);
`ifdef ACC_SATURATE_EN
    sat_exp = row(32'h7FFF_FFFF, 32'h8000_0000);
`else
    sat_exp = row(32'h8000_0000, 32'h7FFF_FFFF);
`endif
    drain = 1'b1; tick(); drain = 1'b0;
    check_val("ovf.row0", out_data, sat_exp);
    out_ready = 1'b1; tick();
    check_val("ovf.row1", out_data, 64'd0);
    tick();
    check_val("mid.valid", 64'(out_valid), 64'd1);

    // Async reset mid-drain
    reset_n = 1'b0; #1;
    check_val("arst.valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    tick();
    check_idle("arst");
    reset_n = 1'b1;
    tick();
    check_idle("arst.rel");

    // Accumulate onto reset rows must yield the added values alone
    for (int i = 0; i < DEPTH; i++) put(row(32'(i+1), 32'(i+1)), 1'b1);
    drain = 1'b1; tick(); drain = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_val("zrow.data", out_data, row(32'(i+1), 32'(i+1)));
      tick();
    end
    check_val("zrow.done", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
